uart_echo_fifo: RTL and testbench

Parametrised UART echo engine: once activated, it buffers received bytes in an internal FIFO and retransmits each one through the UART transmitter. A session ends when a programmable terminator byte has been received and echoed. The FIFO decouples receive bursts from transmitter busy time. The block sits between the UART rx/tx cores and the command dispatcher, which gives it control through `activate`/`done`.

---
 rtl/uart_echo_pkg.sv | 18 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_echo_fifo.sv | 128 ++++++++++++
 tb/tb_uart_echo_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo engine.
package uart_echo_pkg;

  localparam logic [7:0] TERM_DEFAULT = 8'h55;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } echo_state_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_WAIT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and synchronous flush.
module sync_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr_en;
  logic              w_rd_en;

  // Full/empty are taken from the count at cycle start, so a push into a full FIFO is lost even with a concurrent pop.
  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_wr_en = push && !full && !flush;
  assign w_rd_en = pop && !empty && !flush;
  assign dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo engine: buffers received bytes and retransmits them until the
// terminator byte has been echoed, then reports completion via done.
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 16,
  parameter logic [DATA_W-1:0] TERM   = DATA_W'(TERM_DEFAULT),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              activate,
  output logic              done,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic [CNT_W-1:0]  echo_cnt,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  echo_state_t       r_state;
  echo_state_t       w_state_nxt;
  tx_state_t         r_tx_state;
  tx_state_t         w_tx_nxt;
  logic              w_run;
  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_dout;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (rx_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx_state <= T_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_state <= w_tx_nxt;
    end
  end

  // Session control; dropping activate mid-session aborts straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (activate) w_state_nxt = RECV;
      RECV: begin
        if (!activate)                       w_state_nxt = IDLE;
        else if (rx_ready && rx_data == TERM) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!activate)                            w_state_nxt = IDLE;
        else if (w_empty && r_tx_state == T_IDLE) w_state_nxt = DONE;
      end
      DONE:  if (!activate && !rx_ready && !tx_active) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt = r_tx_state;
    if (!w_run) begin
      w_tx_nxt = T_IDLE;
    end else begin
      case (r_tx_state)
        T_IDLE:  if (w_pop) w_tx_nxt = T_WAIT;
        T_WAIT:  if (tx_done) w_tx_nxt = T_IDLE;
        default: w_tx_nxt = T_IDLE;
      endcase
    end
  end

  // Datapath controls decoded from the current states.
  always_comb begin
    w_run   = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_clear = 1'b0;
    w_flush = 1'b0;
    w_run   = ((r_state == RECV) || (r_state == DRAIN)) && activate;
    w_push  = (r_state == RECV) && activate && rx_ready;
    w_pop   = w_run && (r_tx_state == T_IDLE) && !w_empty && !tx_active;
    w_clear = (r_state == IDLE) && activate;
    w_flush = w_clear || (((r_state == RECV) || (r_state == DRAIN)) && !activate);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      echo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      done     <= (w_state_nxt == DONE);
      tx_start <= w_pop;
      if (w_pop) tx_data <= w_dout;
      if (w_clear)                             echo_cnt <= '0;
      else if (w_pop && (echo_cnt != CNT_MAX)) echo_cnt <= echo_cnt + CNT_W'(1);
      if (w_clear)              overflow <= 1'b0;
      else if (w_push && w_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Randomized self-checking bench for uart_echo_fifo with a behavioural UART
// transmitter and a queue-based model of which bytes must come back.
module tb_uart_echo_fifo;

  localparam int              DEPTH   = 8;
  localparam int              CNT_W   = 3;
  localparam int              CNT_SAT = (1 << CNT_W) - 1;
  localparam logic [7:0]      TERM_B  = 8'h55;

  logic             clk;
  logic             reset;
  logic             activate;
  logic             done;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             tx_active;
  logic             tx_done;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic [CNT_W-1:0] echo_cnt;
  logic             overflow;

  logic       stall;
  logic       tx_busy;
  logic       tx_flush;
  int         busy_left;
  logic [7:0] cur_byte;
  logic [7:0] got_q[$];
  logic [7:0] stim_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         start_while_busy = 0;
  int         hold_err = 0;

  assign tx_active = tx_busy | stall;

  uart_echo_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH),
    .TERM   (TERM_B),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .activate  (activate),
    .done      (done),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .echo_cnt  (echo_cnt),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural transmitter: random busy time per byte, then a tx_done strobe.
  initial begin
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    busy_left = 0;
    cur_byte  = 8'h00;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_flush) begin
        tx_busy   = 1'b0;
        busy_left = 0;
      end else begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            tx_done = 1'b1;
            tx_busy = 1'b0;
            if (tx_data !== cur_byte) hold_err++;
          end
        end
        if (tx_start === 1'b1) begin
          if (tx_busy) start_while_busy++;
          cur_byte = tx_data;
          got_q.push_back(tx_data);
          tx_busy   = 1'b1;
          busy_left = int'($urandom_range(3, 12));
        end
      end
    end
  end

  task automatic fill_stim(input int n);
    logic [7:0] b;
    stim_q.delete();
    for (int i = 0; i < n - 1; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == TERM_B);
      stim_q.push_back(b);
    end
    stim_q.push_back(TERM_B);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done !== 1'b1 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Expected echo: everything when the FIFO never fills, else only the first DEPTH bytes.
  task automatic run_session(input bit stalled, input bit do_lat, input int n_extra);
    int base;
    int kept;
    int gap;
    base     = got_q.size();
    stall    = stalled;
    activate = 1'b1;
    @(negedge clk);
    chk("cnt_clear", 32'(echo_cnt), 32'd0);
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("done_low", 32'(done), 32'd0);
    foreach (stim_q[i]) begin
      send_byte(stim_q[i]);
      if (do_lat && i == 0) begin
        chk("lat_k1_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("lat_k2_start", 32'(tx_start), 32'd1);
        chk("lat_k2_data", 32'(tx_data), 32'(stim_q[0]));
      end
      gap = do_lat ? 20 : (stalled ? 0 : int'($urandom_range(0, 14)));
      repeat (gap) @(negedge clk);
    end
    for (int e = 0; e < n_extra; e++) begin
      send_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    if (stalled) begin
      repeat (4) @(negedge clk);
      stall = 1'b0;
    end
    wait_done();
    kept = (stalled && stim_q.size() > DEPTH) ? DEPTH : stim_q.size();
    chk("echo_len", 32'(got_q.size() - base), 32'(kept));
    for (int i = 0; i < kept && base + i < got_q.size(); i++)
      chk("echo_byte", 32'(got_q[base + i]), 32'(stim_q[i]));
    chk("echo_cnt", 32'(echo_cnt), 32'((kept > CNT_SAT) ? CNT_SAT : kept));
    chk("overflow", 32'(overflow), 32'(stalled && stim_q.size() > DEPTH));
    chk("tx_protocol", 32'(start_while_busy + hold_err), 32'd0);
  endtask

  task automatic release_check();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
    end
    activate = 1'b0;
    rx_ready = 1'b1;
    rx_data  = TERM_B;
    @(negedge clk);
    chk("done_rx_block", 32'(done), 32'd1);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("done_release", 32'(done), 32'd0);
  endtask

  initial begin
    int base;
    bit saw_done;
    bit stalled;
    reset    = 1'b1;
    activate = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    stall    = 1'b0;
    tx_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_echo_cnt", 32'(echo_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    stim_q = '{8'h41, 8'h42, 8'h55};
    run_session(1'b0, 1'b1, 0);
    release_check();

    fill_stim(5);
    run_session(1'b1, 1'b0, 0);
    release_check();

    fill_stim(DEPTH + 3);
    run_session(1'b1, 1'b0, 0);
    release_check();

    // Abort with one byte echoed and three queued behind a stalled transmitter.
    base     = got_q.size();
    activate = 1'b1;
    @(negedge clk);
    send_byte(8'h10);
    repeat (2) @(negedge clk);
    stall = 1'b1;
    send_byte(8'h20);
    send_byte(8'h21);
    send_byte(8'h22);
    activate = 1'b0;
    saw_done = 1'b0;
    repeat (2) @(negedge clk);
    stall = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_echoes", 32'(got_q.size() - base), 32'd1);
    chk("abort_done", 32'(saw_done), 32'd0);
    chk("abort_cnt_hold", 32'(echo_cnt), 32'd1);
    chk("abort_ovf_hold", 32'(overflow), 32'd0);

    for (int s = 0; s < 10; s++) begin
      stalled = 1'($urandom_range(0, 1));
      fill_stim(stalled ? int'($urandom_range(1, DEPTH + 3)) : int'($urandom_range(1, DEPTH)));
      run_session(stalled, 1'b0, int'($urandom_range(0, 2)));
      release_check();
    end

    // Asynchronous reset while draining a full FIFO behind a stalled transmitter.
    fill_stim(DEPTH + 2);
    stall    = 1'b1;
    activate = 1'b1;
    @(negedge clk);
    foreach (stim_q[i]) send_byte(stim_q[i]);
    repeat (2) @(negedge clk);
    chk("pre_reset_ovf", 32'(overflow), 32'd1);
    #2;
    reset    = 1'b1;
    activate = 1'b0;
    #1;
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_echo_cnt", 32'(echo_cnt), 32'd0);
    tx_flush = 1'b1;
    stall    = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    tx_flush = 1'b0;
    @(negedge clk);
    fill_stim(int'($urandom_range(1, DEPTH)));
    run_session(1'b0, 1'b0, 1);
    release_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
